// File: rtl/bar_key_driver.sv
// Drives active-low KEY presses so the LED-bar controller steps to a requested level,
// confirming each step by decoding the thermometer bar after a settle interval.
module bar_key_driver #(
  parameter int unsigned PRESS_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 25000000,
  parameter int unsigned MAX_RETRIES   = 2,
  parameter int unsigned KEY_INC       = 0,
  parameter int unsigned KEY_DEC       = 1
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] TARGET,
  input  logic [9:0] LEDR_IN,
  output logic [1:0] KEY_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] ERR,
  output logic [3:0] LEVEL
);

  localparam int unsigned MaxCnt = (PRESS_CYCLES > SETTLE_CYCLES) ? PRESS_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = ($clog2(MaxCnt + 1) > 25) ? $clog2(MaxCnt + 1) : 25;
  localparam int unsigned RetW   = ($clog2(MAX_RETRIES + 1) > 1) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic        KeyIncBit = 1'(KEY_INC);
  localparam logic        KeyDecBit = 1'(KEY_DEC);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCheck   = 3'd1;
  localparam logic [2:0] StPress   = 3'd2;
  localparam logic [2:0] StRelease = 3'd3;
  localparam logic [2:0] StFinish  = 3'd4;

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrBad     = 2'd2;
  localparam logic [1:0] ErrDir     = 2'd3;

  logic [2:0]      state_q, state_d;
  logic [3:0]      target_q, target_d;
  logic [3:0]      level_q, level_d;
  logic            dir_q, dir_d;  // 0 = increment, 1 = decrement
  logic [RetW-1:0] retry_q, retry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;

  // {valid, level}: valid only for k ones contiguous from bit 9 with zeros below
  function automatic logic [4:0] decode_bar(input logic [9:0] bar);
    logic [4:0] res;
    res = '0;
    for (int k = 0; k <= 10; k++) begin
      if (bar == ~(10'h3FF >> k)) res = {1'b1, 4'(k)};
    end
    return res;
  endfunction

  logic [4:0] dec;
  logic       dec_ok;
  logic [3:0] dec_lvl;
  logic       step_ok;

  always_comb begin
    dec     = decode_bar(LEDR_IN);
    dec_ok  = dec[4];
    dec_lvl = dec[3:0];
    step_ok = dir_q ? (4'(dec_lvl + 4'd1) == level_q) : (dec_lvl == 4'(level_q + 4'd1));
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    level_d  = level_q;
    dir_d    = dir_q;
    retry_d  = retry_q;
    err_d    = err_q;
    cnt_d    = cnt_q + CntW'(1);
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (START) begin
          target_d = TARGET;
          err_d    = ErrOk;
          state_d  = StCheck;
          if (TARGET > 4'd10) begin
            err_d   = ErrBad;
            state_d = StFinish;
          end
        end
      end
      StCheck: begin
        cnt_d = '0;
        if (!dec_ok) begin
          err_d   = ErrBad;
          state_d = StFinish;
        end else begin
          level_d = dec_lvl;
          if (dec_lvl == target_q) begin
            state_d = StFinish;
          end else begin
            dir_d   = (dec_lvl > target_q);
            retry_d = '0;
            state_d = StPress;
          end
        end
      end
      StPress: begin
        if (cnt_q == CntW'(PRESS_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          if (!dec_ok) begin
            err_d   = ErrBad;
            state_d = StFinish;
          end else begin
            // level_q still holds the level seen before this press
            level_d = dec_lvl;
            if (dec_lvl == level_q) begin
              if (retry_q == RetW'(MAX_RETRIES)) begin
                err_d   = ErrTimeout;
                state_d = StFinish;
              end else begin
                retry_d = retry_q + RetW'(1);
                state_d = StPress;
              end
            end else if (step_ok) begin
              state_d = StCheck;
            end else begin
              err_d   = ErrDir;
              state_d = StFinish;
            end
          end
        end
      end
      StFinish: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      target_q <= '0;
      level_q  <= '0;
      dir_q    <= 1'b0;
      retry_q  <= '0;
      cnt_q    <= '0;
      err_q    <= ErrOk;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      level_q  <= level_d;
      dir_q    <= dir_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode straight from state so reset releases the key immediately
  always_comb begin
    KEY_OUT = 2'b11;
    if (state_q == StPress) KEY_OUT[dir_q ? KeyDecBit : KeyIncBit] = 1'b0;
    BUSY  = (state_q == StCheck) || (state_q == StPress) || (state_q == StRelease);
    DONE  = (state_q == StFinish);
    ERR   = err_q;
    LEVEL = level_q;
  end

endmodule

// File: tb/tb_bar_key_driver.sv
// Scoreboard bench for bar_key_driver: a behavioural bar controller answers key presses,
// expected results are queued at START and checked when DONE pulses.
module tb_bar_key_driver;

  localparam int PressCycles  = 4;
  localparam int SettleCycles = 16;
  localparam int MaxRetries   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] target = 4'd0;
  logic [9:0] ledr;
  logic [1:0] key;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [3:0] level;

  always #5 clk = ~clk;

  bar_key_driver #(
    .PRESS_CYCLES (PressCycles),
    .SETTLE_CYCLES(SettleCycles),
    .MAX_RETRIES  (MaxRetries),
    .KEY_INC      (0),
    .KEY_DEC      (1)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .START   (start),
    .TARGET  (target),
    .LEDR_IN (ledr),
    .KEY_OUT (key),
    .BUSY    (busy),
    .DONE    (done),
    .ERR     (err),
    .LEVEL   (level)
  );

  // Bar controller model: one step per key release, saturating at 0 and 10
  int         bar_lvl = 0;
  int         load_val = 0;
  bit         load = 1'b0;
  bit         frozen = 1'b0;
  bit         ovr = 1'b0;
  logic [9:0] ovr_pat = '0;
  logic [1:0] mdl_prev = 2'b11;

  function automatic logic [9:0] pattern(input int k);
    logic [9:0] p;
    for (int i = 0; i < 10; i++) p[i] = (i >= 10 - k);
    return p;
  endfunction

  always @(negedge clk) begin
    if (load) bar_lvl <= load_val;
    else if (!frozen) begin
      if (!mdl_prev[0] && key[0] && bar_lvl < 10) bar_lvl <= bar_lvl + 1;
      else if (!mdl_prev[1] && key[1] && bar_lvl > 0) bar_lvl <= bar_lvl - 1;
    end
    mdl_prev <= key;
  end

  assign ledr = ovr ? ovr_pat : pattern(bar_lvl);

  typedef struct {
    int err;
    int lvl;
    bit lvl_care;
    int n_inc;
    int n_dec;
    int lat;  // -1: not checked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic monitor();
    int         lat = 0;
    int         n_inc = 0;
    int         n_dec = 0;
    int         low_len[2];
    bit         saw00 = 1'b0;
    logic [1:0] prev = 2'b11;
    exp_t       e;
    low_len[0] = 0;
    low_len[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev       = 2'b11;
        low_len[0] = 0;
        low_len[1] = 0;
      end else begin
        if (start && !busy && !done) begin
          lat = 0; n_inc = 0; n_dec = 0; saw00 = 1'b0;
        end else begin
          lat++;
        end
        if (key == 2'b00) saw00 = 1'b1;
        for (int b = 0; b < 2; b++) begin
          if (!key[b]) begin
            if (prev[b]) begin
              if (b == 0) n_inc++;
              else n_dec++;
            end
            low_len[b]++;
          end else if (!prev[b]) begin
            check($sformatf("pulse_len_key%0d", b), low_len[b], PressCycles);
            low_len[b] = 0;
          end
        end
        if (done) begin
          check("done_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("err", err, e.err);
            if (e.lvl_care) check("level", level, e.lvl);
            check("inc_presses", n_inc, e.n_inc);
            check("dec_presses", n_dec, e.n_dec);
            if (e.lat >= 0) check("latency", lat, e.lat);
            check("both_keys_low", saw00, 0);
            check("busy_in_done", busy, 0);
          end
        end
        prev = key;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bar(input int l);
    load_val = l;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) tick();
    check("completed_in_time", sb.size(), 0);
    sb.delete();
  endtask

  task automatic push_exp(input int e_err, input int e_lvl, input bit care,
                          input int ni, input int nd, input int lat);
    exp_t e;
    e.err = e_err; e.lvl = e_lvl; e.lvl_care = care;
    e.n_inc = ni; e.n_dec = nd; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic run(input logic [3:0] t, input int e_err, input int e_lvl, input bit care,
                     input int ni, input int nd, input int lat);
    push_exp(e_err, e_lvl, care, ni, nd, lat);
    target = t;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done();
  endtask

  localparam int Step = PressCycles + SettleCycles + 1;

  initial begin
    bit found;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check("rst_key", key, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_level", level, 0);
    rst = 1'b0;
    tick();

    set_bar(5);
    run(4'd8, 0, 8, 1, 3, 0, 2 + 3 * Step);
    set_bar(5);
    run(4'd0, 0, 0, 1, 0, 5, 2 + 5 * Step);
    check("bar_final_zero", ledr, 10'b0);
    set_bar(3);
    run(4'd3, 0, 3, 1, 0, 0, 2);

    // Frozen bar: one press plus two retries, each press+settle is 20 cycles
    frozen = 1'b1;
    set_bar(5);
    run(4'd7, 1, 5, 1, 3, 0, 2 + 3 * (PressCycles + SettleCycles));
    frozen = 1'b0;
    repeat (3) tick();
    check("err_holds", err, 1);

    ovr_pat = 10'b1010000000;
    ovr     = 1'b1;
    run(4'd4, 2, 0, 0, 0, 0, 2);
    ovr = 1'b0;
    run(4'd12, 2, 0, 0, 0, 0, 1);

    set_bar(0);
    run(4'd10, 0, 10, 1, 10, 0, 2 + 10 * Step);
    set_bar(10);
    run(4'd0, 0, 0, 1, 0, 10, 2 + 10 * Step);

    // Reset during the second cycle of a press
    set_bar(2);
    target = 4'd6;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (!key[0]) found = 1'b1;
    end
    check("press_reached", found, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_key", key, 2'b11);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();

    // Fresh request completes; a START pulsed while busy is ignored
    set_bar(2);
    push_exp(0, 6, 1, 4, 0, 2 + 4 * Step);
    target = 4'd6;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (30) tick();
    target = 4'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done();
    repeat (10) tick();
    check("idle_after_done", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bar_key_driver.md
Name: bar_key_driver

Overview:
- Initiator side of the push-button/LED-bar interface: takes a requested bar level and generates active-low KEY press pulses so the bar controller steps the 10-LED thermometer bar to that level.
- Watches the bar outputs after every press to confirm each step.
- Sits between a host/test sequencer and the bar controller's KEY[1:0] inputs.
- Typical use: automated board self-test and remote bar control.

Parameters:
- PRESS_CYCLES, 4: clock cycles a key is held low per step.
- SETTLE_CYCLES, 25000000: cycles after release before the bar is sampled. Must be ≥ the controller's inter-step wait.
- MAX_RETRIES, 2: unchanged-bar samples tolerated per step before a timeout.
- KEY_INC, 0: KEY_OUT bit that increments the bar.
- KEY_DEC, 1: KEY_OUT bit that decrements the bar.

Ports:
- CLOCK_50, input, 1: system clock; all state updates on posedge.
- RESET, input, 1: asynchronous, active-high reset.
- START, input, 1: request strobe, sampled only in IDLE.
- TARGET, input, 4: requested level 0..10, latched on an accepted START.
- LEDR_IN, input, 10: bar pattern from the controller.
- KEY_OUT, output, 2: active-low key drive to the controller.
- BUSY, output, 1: high from an accepted START until DONE.
- DONE, output, 1: one-cycle completion pulse.
- ERR, output, 2: result code. 0 = ok, 1 = timeout, 2 = bad pattern or bad target, 3 = wrong direction.
- LEVEL, output, 4: last decoded bar level.

Behaviour:
- Reset (async, immediate):
  - KEY_OUT = 2'b11; BUSY = 0; DONE = 0; ERR = 0; LEVEL = 0.
  - State = IDLE; all counters = 0.
  - Reset mid-press releases the key within the reset assertion; no partial step is resumed.
- Bar decode:
  - A valid pattern has k ones contiguous from bit 9 down, zeros below, k in 0..10. Example: 10'b1111100000 = level 5.
  - Any other pattern is invalid.
- KEY_OUT is never 2'b00. At most one key is low, and only in PRESS.
- IDLE:
  - BUSY = 0.
  - START = 1 latches TARGET and sets BUSY = 1.
  - If TARGET > 10: ERR = 2, go to FINISH.
  - Otherwise go to CHECK.
  - START while BUSY is ignored.
- CHECK (1 cycle):
  - Register LEVEL from LEDR_IN.
  - Invalid pattern: ERR = 2, go to FINISH.
  - LEVEL == target: ERR = 0, go to FINISH.
  - Otherwise: prev_level = LEVEL; dir = INC if LEVEL < target, else DEC; retry counter = 0; go to PRESS.
- PRESS:
  - Hold KEY_OUT[dir] low for exactly PRESS_CYCLES cycles, then go to RELEASE.
- RELEASE:
  - KEY_OUT = 2'b11; count SETTLE_CYCLES; then decode the bar.
  - Level moved exactly one step in dir: go to CHECK.
  - Level unchanged, retries < MAX_RETRIES: increment retries, go to PRESS.
  - Level unchanged, retries == MAX_RETRIES: ERR = 1, go to FINISH.
  - Level moved opposite to dir or by more than one step: ERR = 3.
  - Invalid pattern: ERR = 2.
- FINISH (1 cycle):
  - DONE = 1; BUSY drops to 0 in the same cycle; go to IDLE.
  - ERR holds its value until the next accepted START, which clears it to 0.
- Latency:
  - Already at target: START → DONE in 2 cycles (IDLE→CHECK→FINISH).
  - Each clean step adds PRESS_CYCLES + SETTLE_CYCLES + 1 cycles.
- Counters must be wide enough for the SETTLE_CYCLES default (25-bit minimum) and must reset to 0 on every state entry.
- Boundaries:
  - Target 0 or 10 from the far end takes 10 steps.
  - The driver never presses INC at level 10 or DEC at level 0, because CHECK terminates first.

Test Plan (PRESS_CYCLES = 4, SETTLE_CYCLES = 16, MAX_RETRIES = 2; bench models the bar controller):
- Bar 1111100000, TARGET = 8 → three KEY_OUT[0] low pulses of 4 cycles each; LEVEL = 8; DONE with ERR = 0; KEY_OUT[1] never low.
- Bar 1111100000, TARGET = 0 → five KEY_OUT[1] pulses; final bar 0000000000; DONE with ERR = 0.
- Bar 1110000000, TARGET = 3 → DONE exactly 2 cycles after START; no key activity; ERR = 0.
- Bar model frozen, TARGET = 7 from level 5 → exactly 3 presses (1 + 2 retries); then DONE with ERR = 1.
- LEDR_IN = 1010000000 → ERR = 2 on first CHECK. Separately, TARGET = 12 → ERR = 2 with no key press.
- RESET asserted during the 2nd PRESS cycle → KEY_OUT = 11 and BUSY = 0 asynchronously. After release, a new START completes normally; a START pulsed while BUSY is ignored.
